// File: rtl/token_shaper_pkg.sv
// token_shaper_pkg
// Shared definitions for token_req_shaper and its FIFO: width helpers for
// occupancy, pointer and wait counters, the statistics counter width, and the
// bucket constants that the token_bucket bench also reuses.
package token_shaper_pkg;

    localparam int unsigned STAT_W = 16;

    // Reference bucket configuration used when pairing with token_bucket
    localparam int unsigned BUCKET_DEN       = 16;
    localparam int unsigned BUCKET_RATE_NUM  = 3;
    localparam int unsigned BUCKET_BURST_MAX = 8;

    // Occupancy counter must represent 0..depth inclusive
    function automatic int unsigned cnt_width(input int unsigned depth);
        return unsigned'($clog2(depth + 1));
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth < 2) ? 1 : unsigned'($clog2(depth));
    endfunction

    function automatic int unsigned wait_width(input int unsigned max_wait);
        return unsigned'($clog2(max_wait + 1));
    endfunction

endpackage

// File: rtl/token_shaper_fifo.sv
// token_shaper_fifo
// Circular buffer with separate occupancy count. Pointers wrap naturally
// (DEPTH is a power of two). Push is ignored when full, pop when empty.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   push_i, wdata_i  write request and data
//   pop_i            read request (advances head)
//   head_o           current head entry
//   full_o, empty_o  occupancy flags from registered count
//   count_o          occupancy
module token_shaper_fifo
    import token_shaper_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_i,
    input  logic [DATA_W-1:0]           wdata_i,
    input  logic                        pop_i,
    output logic [DATA_W-1:0]           head_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [cnt_width(DEPTH)-1:0] count_o
);

    localparam int unsigned PtrW = ptr_width(DEPTH);
    localparam int unsigned CntW = cnt_width(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: stale entries are unreachable once pointers clear
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/token_req_shaper.sv
// token_req_shaper
// Buffers upstream items and requests tokens from a token_bucket; each grant
// pops one item and re-emits it as a one-cycle registered pulse. Tracks how
// long the head item has waited and flags grants seen with nothing pending.
// Optional macro TOKEN_SHAPER_STATS_EN adds saturating pop / stall-cycle
// counters; without it grant_cnt_o and stall_cnt_o are tied to 0.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid_i, in_data_i        upstream item, in_ready_o = not full
//   req_o                        item pending (to bucket req_i)
//   grant_i                      bucket grant, same-cycle response to req_o
//   out_valid_o, out_data_o      granted item (pulse), data holds when idle
//   count_o                      FIFO occupancy
//   stall_o                      head has waited MAX_WAIT cycles
//   err_o                        sticky: grant while req_o was low
//   grant_cnt_o, stall_cnt_o     optional statistics
module token_req_shaper
    import token_shaper_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid_i,
    input  logic [DATA_W-1:0]           in_data_i,
    output logic                        in_ready_o,
    output logic                        req_o,
    input  logic                        grant_i,
    output logic                        out_valid_o,
    output logic [DATA_W-1:0]           out_data_o,
    output logic [cnt_width(DEPTH)-1:0] count_o,
    output logic                        stall_o,
    output logic                        err_o,
    output logic [STAT_W-1:0]           grant_cnt_o,
    output logic [STAT_W-1:0]           stall_cnt_o
);

    localparam int unsigned WaitW = wait_width(MAX_WAIT);

    logic              fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              push, pop;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;

    // Handshake flags come only from registered FIFO state
    assign in_ready_o = !fifo_full;
    assign req_o      = !fifo_empty;
    assign push       = in_valid_i && !fifo_full;
    assign pop        = grant_i && !fifo_empty;

    token_shaper_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (in_data_i),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    always_comb begin
        out_valid_d = pop;
        out_data_d  = pop ? fifo_head : out_data_q;
        err_d       = err_q | (grant_i & fifo_empty);
        if (pop || fifo_empty) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WaitW'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign stall_o     = (wait_cnt_q == WaitW'(MAX_WAIT));
    assign err_o       = err_q;

`ifdef TOKEN_SHAPER_STATS_EN
    logic [STAT_W-1:0] grant_cnt_q, grant_cnt_d;
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (pop && (grant_cnt_q != '1))     grant_cnt_d = grant_cnt_q + STAT_W'(1);
        if (stall_o && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign grant_cnt_o = grant_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
`else
    assign grant_cnt_o = '0;
    assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_token_req_shaper.sv
// tb_token_req_shaper
// Drives token_req_shaper with a behavioural token bucket (DEN=16, RATE=3,
// BURST=8) or directed/random grants, keeps a queue-based reference model and
// checks granted data through a scoreboard popped by a separate monitor.
module tb_token_req_shaper;
    import token_shaper_pkg::*;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 8;
    localparam int MAX_WAIT = 64;
    localparam int TOK_FULL = int'(BUCKET_BURST_MAX * BUCKET_DEN);

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid_i;
    logic [DATA_W-1:0] in_data_i;
    logic              in_ready_o;
    logic              req_o;
    logic              grant_i;
    logic              out_valid_o;
    logic [DATA_W-1:0] out_data_o;
    logic [3:0]        count_o;
    logic              stall_o;
    logic              err_o;
    logic [15:0]       grant_cnt_o;
    logic [15:0]       stall_cnt_o;

    token_req_shaper #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_ready_o  (in_ready_o),
        .req_o       (req_o),
        .grant_i     (grant_i),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .count_o     (count_o),
        .stall_o     (stall_o),
        .err_o       (err_o),
        .grant_cnt_o (grant_cnt_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [DATA_W-1:0] mq[$];     // items held by the shaper
    logic [DATA_W-1:0] exp_q[$];  // granted items awaiting output
    int  m_wait;
    bit  m_err;
    bit  m_out_valid;
    int  tokens;
    bit  bucket_en;
    bit  force_mode;
    bit  force_val;
    bit  last_push;
    int  out_pulses;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid_o), 32'(m_out_valid));
        chk("count", 32'(count_o), 32'(mq.size()));
        chk("in_ready", 32'(in_ready_o), 32'(mq.size() != DEPTH));
        chk("req", 32'(req_o), 32'(mq.size() != 0));
        chk("stall", 32'(stall_o), 32'(m_wait == MAX_WAIT));
        chk("err", 32'(err_o), 32'(m_err));
    endtask

    // One clock: choose grant, apply edge, update model, check just after edge
    task automatic step();
        int pre;
        bit pop;
        pre = mq.size();
        if (force_mode) grant_i = force_val;
        else            grant_i = bucket_en && (pre != 0) && (tokens >= int'(BUCKET_DEN));
        @(posedge clk);
        pop       = grant_i && (pre != 0);
        last_push = in_valid_i && (pre < DEPTH);
        if (grant_i && pre == 0) m_err = 1'b1;
        if (pop) exp_q.push_back(mq.pop_front());
        if (last_push) mq.push_back(in_data_i);
        m_out_valid = pop;
        if (pop || pre == 0)       m_wait = 0;
        else if (m_wait < MAX_WAIT) m_wait++;
        tokens += int'(BUCKET_RATE_NUM);
        if (!force_mode && grant_i) tokens -= int'(BUCKET_DEN);
        if (tokens > TOK_FULL) tokens = TOK_FULL;
        #1;
        if (out_valid_o) out_pulses++;
        check_outputs();
    endtask

    task automatic reset_model();
        mq.delete();
        exp_q.delete();
        m_wait = 0;
        m_err = 1'b0;
        m_out_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid_o), 32'd0);
        chk({tag, "_out_data"}, 32'(out_data_o), 32'd0);
        chk({tag, "_count"}, 32'(count_o), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready_o), 32'd1);
        chk({tag, "_req"}, 32'(req_o), 32'd0);
        chk({tag, "_stall"}, 32'(stall_o), 32'd0);
        chk({tag, "_err"}, 32'(err_o), 32'd0);
        chk({tag, "_grant_cnt"}, 32'(grant_cnt_o), 32'd0);
        chk({tag, "_stall_cnt"}, 32'(stall_cnt_o), 32'd0);
    endtask

    // Scoreboard monitor: every output pulse must match the oldest granted item
    always @(negedge clk) begin
        if (!rst && out_valid_o) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL out_unexpected: got data %0d expected no output", out_data_o);
            end else begin
                chk("out_data", 32'(out_data_o), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [DATA_W-1:0] d;

        rst = 1'b1;
        in_valid_i = 1'b0;
        in_data_i = '0;
        grant_i = 1'b0;
        bucket_en = 1'b0;
        force_mode = 1'b0;
        force_val = 1'b0;
        tokens = TOK_FULL;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("rst");
        rst = 1'b0;
        repeat (3) step();

        // Burst fill with grants held off, then let the full bucket drain it
        for (int i = 1; i <= 8; i++) begin
            in_valid_i = 1'b1;
            in_data_i = DATA_W'(i);
            step();
        end
        in_valid_i = 1'b0;
        chk("burst_count", 32'(count_o), 32'd8);
        chk("burst_in_ready", 32'(in_ready_o), 32'd0);
        bucket_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("burst_pulse", 32'(out_valid_o), 32'd1);
        end
        step();
        chk("burst_end", 32'(out_valid_o), 32'd0);

        // Sustained input: output rate set by the bucket
        d = 8'd0;
        out_pulses = 0;
        in_valid_i = 1'b1;
        for (int i = 0; i < 400; i++) begin
            in_data_i = d;
            step();
            if (last_push) d = d + 8'd1;
        end
        chk("rate_window", 32'(out_pulses >= 71 && out_pulses <= 79), 32'd1);
        in_valid_i = 1'b0;
        n = 0;
        while (mq.size() != 0 && n < 300) begin
            step();
            n++;
        end
        chk("rate_drained", 32'(mq.size()), 32'd0);

        // Random traffic with random grants only while something is pending
        force_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_valid_i = 1'($urandom_range(0, 1));
            in_data_i = DATA_W'($urandom);
            force_val = (mq.size() != 0) && ($urandom_range(0, 2) != 0);
            step();
        end
        in_valid_i = 1'b0;
        n = 0;
        while (mq.size() != 0 && n < 20) begin
            force_val = 1'b1;
            step();
            n++;
        end
        force_val = 1'b0;
        step();
        chk("random_drained", 32'(count_o), 32'd0);

        // Head-of-line stall
        in_valid_i = 1'b1;
        in_data_i = 8'hA5;
        step();
        in_valid_i = 1'b0;
        n = 0;
        while (!stall_o && n < 100) begin
            step();
            n++;
        end
        chk("stall_latency", 32'(n), 32'(MAX_WAIT));
        repeat (3) step();
        chk("stall_held", 32'(stall_o), 32'd1);
        force_val = 1'b1;
        step();
        chk("stall_cleared", 32'(stall_o), 32'd0);
        chk("stall_pop", 32'(out_valid_o), 32'd1);
        force_val = 1'b0;
        step();

        // Grant while empty
        chk("err_pre", 32'(err_o), 32'd0);
        force_val = 1'b1;
        step();
        chk("err_set", 32'(err_o), 32'd1);
        chk("err_no_out", 32'(out_valid_o), 32'd0);
        chk("err_count", 32'(count_o), 32'd0);
        force_val = 1'b0;
        repeat (5) step();
        chk("err_sticky", 32'(err_o), 32'd1);

        // Reset mid-operation with an output pulse in flight
        for (int i = 0; i < 6; i++) begin
            in_valid_i = 1'b1;
            in_data_i = DATA_W'(8'h40 + i);
            step();
        end
        in_valid_i = 1'b0;
        force_val = 1'b1;
        step();
        chk("mid_pulse", 32'(out_valid_o), 32'd1);
        chk("mid_count", 32'(count_o), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        reset_model();
        chk("mid_rst_valid", 32'(out_valid_o), 32'd0);
        chk("mid_rst_count", 32'(count_o), 32'd0);
        chk("mid_rst_req", 32'(req_o), 32'd0);
        @(posedge clk);
        #1;
        check_reset_values("mid_rst");
        rst = 1'b0;
        force_val = 1'b0;
        repeat (3) step();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
